// File: rtl/alimentador_instrucoes_if.sv
// Bus between the instruction feeder and its environment: program load port,
// Start/Done control and the DIN/Run issue path. Step exists only with STEP_MODE_EN.
interface alimentador_instrucoes_if #(
  parameter int unsigned ADDR_W = 5
);
  // Start, Done, ProgWe and Step are levels sampled on the rising clock edge;
  // Run is a one-cycle strobe qualifying DIN. There is no back-pressure:
  // the processor acknowledges each instruction with Done.
  logic              Start;
  logic              Done;
  logic              ProgWe;
  logic [ADDR_W-1:0] ProgAddr;
  logic [15:0]       ProgData;
`ifdef STEP_MODE_EN
  logic              Step;
`endif
  logic [15:0]       DIN;
  logic              Run;
  logic [ADDR_W-1:0] PC;
  logic              Busy;
  logic              Halted;
  logic              Erro;
  logic [2:0]        dbg_state;

`ifdef STEP_MODE_EN
  modport master (
    input  Start, Done, ProgWe, ProgAddr, ProgData, Step,
    output DIN, Run, PC, Busy, Halted, Erro, dbg_state
  );
  modport slave (
    output Start, Done, ProgWe, ProgAddr, ProgData, Step,
    input  DIN, Run, PC, Busy, Halted, Erro, dbg_state
  );
`else
  modport master (
    input  Start, Done, ProgWe, ProgAddr, ProgData,
    output DIN, Run, PC, Busy, Halted, Erro, dbg_state
  );
  modport slave (
    output Start, Done, ProgWe, ProgAddr, ProgData,
    input  DIN, Run, PC, Busy, Halted, Erro, dbg_state
  );
`endif
endinterface

// File: rtl/alimentador_instrucoes.sv
// Instruction feeder for processador_multiciclo: loadable program memory, Run/DIN
// issue, mvi immediate, halt word and Done timeout. Optional STEP_MODE_EN adds Step.
module alimentador_instrucoes #(
  parameter int unsigned ADDR_W    = 5,
  parameter logic [2:0]  MVI_OP    = 3'b001,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  alimentador_instrucoes_if.master bus
);
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_IMM, S_WAIT, S_HALT, S_ERROR
  } state_t;

  state_t            state_q;
  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       word_q;
  logic [15:0]       din_q;
  logic              run_q;
  logic              busy_q;
  logic              halted_q;
  logic              erro_q;
  logic              done_q;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        cnt_q;

  logic [ADDR_W-1:0] pc_p1;
  logic [ADDR_W-1:0] pc_p2;
  logic [15:0]       rd_word;
  logic              step_ok;
  logic              done_hit;
  logic              prog_ok;

`ifdef STEP_MODE_EN
  assign step_ok = bus.Step;
`else
  assign step_ok = 1'b1;
`endif

  assign pc_p1    = pc_q + ADDR_W'(1);
  assign pc_p2    = pc_q + ADDR_W'(2);
  // The read address is PC in FETCH and PC+1 in ISSUE so the mvi immediate is
  // ready one cycle after the opcode; the registers below form the read latch.
  assign rd_word  = (state_q == S_ISSUE) ? mem_q[pc_p1] : mem_q[pc_q];
  assign done_hit = bus.Done | done_q;
  assign prog_ok  = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERROR);

  always_ff @(posedge Clock) begin
    if (bus.ProgWe && prog_ok) begin
      mem_q[bus.ProgAddr] <= bus.ProgData;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      word_q   <= '0;
      din_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      erro_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      run_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALT, S_ERROR: begin
          if (bus.Start) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
            erro_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
          end
        end
        S_FETCH: begin
          word_q  <= rd_word;
          state_q <= S_ISSUE;
          // A halt word is never presented to the processor.
          if (rd_word != HALT_WORD) begin
            din_q <= rd_word;
            run_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          cnt_q  <= '0;
          done_q <= 1'b0;
          if (word_q == HALT_WORD) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else if (word_q[8:6] == MVI_OP) begin
            state_q <= S_IMM;
            din_q   <= rd_word;
          end else begin
            state_q <= S_WAIT;
            pc_q    <= pc_p1;
          end
        end
        S_IMM: begin
          pc_q <= pc_p2;
          if (bus.Done && step_ok) begin
            state_q <= S_FETCH;
          end else begin
            state_q <= S_WAIT;
            done_q  <= bus.Done;
          end
        end
        S_WAIT: begin
          // A completed instruction held back by Step no longer counts toward the timeout.
          if (done_hit) begin
            if (step_ok) begin
              state_q <= S_FETCH;
              cnt_q   <= '0;
              done_q  <= 1'b0;
            end else begin
              done_q <= 1'b1;
            end
          end else if (cnt_q == TO_LAST) begin
            state_q <= S_ERROR;
            cnt_q   <= cnt_q + 8'd1;
            busy_q  <= 1'b0;
            erro_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.DIN       = din_q;
  assign bus.Run       = run_q;
  assign bus.PC        = pc_q;
  assign bus.Busy      = busy_q;
  assign bus.Halted    = halted_q;
  assign bus.Erro      = erro_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alimentador_instrucoes.sv
// Directed bench for alimentador_instrucoes: a default instance (ADDR_W=5) and
// a small one (ADDR_W=2) used for the address wrap case.
module tb_alimentador_instrucoes;
  logic Clock;
  logic Resetn;
  int   total;
  int   bad;

  alimentador_instrucoes_if #(.ADDR_W(5)) bus ();
  alimentador_instrucoes_if #(.ADDR_W(2)) bus2 ();

  alimentador_instrucoes #(.ADDR_W(5)) u_dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  alimentador_instrucoes #(.ADDR_W(2)) u_dut2 (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus2)
  );

  // clock / reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // driver tasks
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [4:0] addr, input logic [15:0] data);
    bus.ProgWe   = 1'b1;
    bus.ProgAddr = addr;
    bus.ProgData = data;
    step();
    bus.ProgWe   = 1'b0;
  endtask

  task automatic load2(input logic [1:0] addr, input logic [15:0] data);
    bus2.ProgWe   = 1'b1;
    bus2.ProgAddr = addr;
    bus2.ProgData = data;
    step();
    bus2.ProgWe   = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (bus.DIN !== 16'h0000) begin bad++; $display("FAIL rst_din: got %h want 0000", bus.DIN); end
    total++; if (bus.Run !== 1'b0) begin bad++; $display("FAIL rst_run: got %b want 0", bus.Run); end
    total++; if (bus.PC !== 5'd0) begin bad++; $display("FAIL rst_pc: got %0d want 0", bus.PC); end
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.Busy); end
    total++; if (bus.Halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", bus.Halted); end
    total++; if (bus.Erro !== 1'b0) begin bad++; $display("FAIL rst_erro: got %b want 0", bus.Erro); end
    @(negedge Clock);
    Resetn = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    load2(2'd0, 16'h1234);
    load2(2'd1, 16'h0008);
    load2(2'd2, 16'h0008);
    load2(2'd3, 16'h0040);
    bus2.Start = 1'b1;
    step();
    bus2.Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (bus2.Run !== 1'b1) begin bad++; $display("FAIL wrap_run%0d: got %b want 1", k, bus2.Run); end
      step();
      bus2.Done = 1'b1;
      step();
      bus2.Done = 1'b0;
    end
    step();
    total++; if (bus2.DIN !== 16'h0040) begin bad++; $display("FAIL wrap_mvi_din: got %h want 0040", bus2.DIN); end
    total++; if (bus2.PC !== 2'd3) begin bad++; $display("FAIL wrap_mvi_pc: got %0d want 3", bus2.PC); end
    step();
    total++; if (bus2.DIN !== 16'h1234) begin bad++; $display("FAIL wrap_imm_din: got %h want 1234", bus2.DIN); end
    step();
    total++; if (bus2.PC !== 2'd1) begin bad++; $display("FAIL wrap_pc: got %0d want 1", bus2.PC); end
  endtask

  task automatic test_halt();
    int runs;
    runs = 0;
    load(5'd0, 16'h0008);
    load(5'd1, 16'hFFFF);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    total++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL halt_fetch_busy: got %b want 1", bus.Busy); end
    total++; if (bus.Run !== 1'b0) begin bad++; $display("FAIL halt_fetch_run: got %b want 0", bus.Run); end
    step();
    total++; if (bus.Run !== 1'b1) begin bad++; $display("FAIL halt_issue_run: got %b want 1", bus.Run); end
    total++; if (bus.DIN !== 16'h0008) begin bad++; $display("FAIL halt_issue_din: got %h want 0008", bus.DIN); end
    step();
    total++; if (bus.Run !== 1'b0) begin bad++; $display("FAIL halt_wait_run: got %b want 0", bus.Run); end
    total++; if (bus.PC !== 5'd1) begin bad++; $display("FAIL halt_wait_pc: got %0d want 1", bus.PC); end
    step();
    step();
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.Run) runs++;
      if (bus.Halted) break;
    end
    total++; if (bus.Halted !== 1'b1) begin bad++; $display("FAIL halt_flag: got %b want 1", bus.Halted); end
    total++; if (bus.PC !== 5'd1) begin bad++; $display("FAIL halt_pc: got %0d want 1", bus.PC); end
    total++; if (runs != 0) begin bad++; $display("FAIL halt_extra_run: got %0d pulses want 0", runs); end
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL halt_busy: got %b want 0", bus.Busy); end
    total++; if (bus.DIN !== 16'h0008) begin bad++; $display("FAIL halt_din_held: got %h want 0008", bus.DIN); end
  endtask

  task automatic test_mvi();
    load(5'd0, 16'h0040);
    load(5'd1, 16'h00A5);
    load(5'd2, 16'hFFFF);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    step();
    total++; if (bus.Run !== 1'b1) begin bad++; $display("FAIL mvi_run: got %b want 1", bus.Run); end
    total++; if (bus.DIN !== 16'h0040) begin bad++; $display("FAIL mvi_din: got %h want 0040", bus.DIN); end
    bus.Done = 1'b1;
    step();
    total++; if (bus.DIN !== 16'h00A5) begin bad++; $display("FAIL mvi_imm_din: got %h want 00a5", bus.DIN); end
    total++; if (bus.Run !== 1'b0) begin bad++; $display("FAIL mvi_imm_run: got %b want 0", bus.Run); end
    step();
    bus.Done = 1'b0;
    total++; if (bus.PC !== 5'd2) begin bad++; $display("FAIL mvi_pc: got %0d want 2", bus.PC); end
    step();
    step();
    total++; if (bus.Halted !== 1'b1) begin bad++; $display("FAIL mvi_halted: got %b want 1", bus.Halted); end
    total++; if (bus.PC !== 5'd2) begin bad++; $display("FAIL mvi_halt_pc: got %0d want 2", bus.PC); end
    total++; if (bus.DIN !== 16'h00A5) begin bad++; $display("FAIL mvi_halt_din: got %h want 00a5", bus.DIN); end
  endtask

  task automatic test_timeout();
    load(5'd0, 16'h0008);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    step();
    step();
    for (int i = 0; i < 15; i++) step();
    total++; if (bus.Erro !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", bus.Erro); end
    step();
    total++; if (bus.Erro !== 1'b1) begin bad++; $display("FAIL to_erro: got %b want 1", bus.Erro); end
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL to_busy: got %b want 0", bus.Busy); end
    total++; if (bus.PC !== 5'd1) begin bad++; $display("FAIL to_pc: got %0d want 1", bus.PC); end
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    total++; if (bus.Erro !== 1'b0) begin bad++; $display("FAIL to_restart_erro: got %b want 0", bus.Erro); end
    total++; if (bus.PC !== 5'd0) begin bad++; $display("FAIL to_restart_pc: got %0d want 0", bus.PC); end
    step();
    total++; if (bus.Run !== 1'b1) begin bad++; $display("FAIL to_restart_run: got %b want 1", bus.Run); end
    total++; if (bus.DIN !== 16'h0008) begin bad++; $display("FAIL to_restart_din: got %h want 0008", bus.DIN); end
    step();
  endtask

  task automatic test_async_reset();
    step();
    step();
    #2;
    Resetn = 1'b0;
    #1;
    total++; if (bus.DIN !== 16'h0000) begin bad++; $display("FAIL ar_din: got %h want 0000", bus.DIN); end
    total++; if (bus.Run !== 1'b0) begin bad++; $display("FAIL ar_run: got %b want 0", bus.Run); end
    total++; if (bus.PC !== 5'd0) begin bad++; $display("FAIL ar_pc: got %0d want 0", bus.PC); end
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL ar_busy: got %b want 0", bus.Busy); end
    @(negedge Clock);
    Resetn = 1'b1;
    step();
    load(5'd1, 16'hFFFF);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    step();
    total++; if (bus.Run !== 1'b1) begin bad++; $display("FAIL ar_rerun: got %b want 1", bus.Run); end
    total++; if (bus.DIN !== 16'h0008) begin bad++; $display("FAIL ar_rerun_din: got %h want 0008", bus.DIN); end
    step();
  endtask

  task automatic test_prog_protect();
    int runs;
    runs = 0;
    bus.ProgWe   = 1'b1;
    bus.ProgAddr = 5'd1;
    bus.ProgData = 16'h0008;
    step();
    bus.ProgWe   = 1'b0;
    bus.Done     = 1'b1;
    step();
    bus.Done     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.Run) runs++;
      if (bus.Halted) break;
    end
    total++; if (bus.Halted !== 1'b1) begin bad++; $display("FAIL wp_halted: got %b want 1", bus.Halted); end
    total++; if (runs != 0) begin bad++; $display("FAIL wp_run: got %0d pulses want 0", runs); end
    total++; if (bus.PC !== 5'd1) begin bad++; $display("FAIL wp_pc: got %0d want 1", bus.PC); end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    Resetn        = 1'b0;
    bus.Start     = 1'b0;
    bus.Done      = 1'b0;
    bus.ProgWe    = 1'b0;
    bus.ProgAddr  = '0;
    bus.ProgData  = '0;
    bus2.Start    = 1'b0;
    bus2.Done     = 1'b0;
    bus2.ProgWe   = 1'b0;
    bus2.ProgAddr = '0;
    bus2.ProgData = '0;
    test_reset();
    test_wrap();
    test_halt();
    test_mvi();
    test_timeout();
    test_async_reset();
    test_prog_protect();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // bench-wide time limit
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
